// File: rtl/serial_sub.sv
// serial_sub: digit-serial A - B - Bin over WIDTH bits, DIGIT bits per clock.
// Start/busy/done handshake; reports unsigned borrow-out and signed overflow.
module serial_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             OVF
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_chk
        $error("serial_sub: illegal WIDTH/DIGIT combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT:0]   dig_diff;
    logic [WIDTH-1:0] dig_w;
    logic [WIDTH-1:0] r_nxt;
    logic             last;

    // One digit step; the extra top bit of the difference is the borrow.
    always_comb begin
        dig_diff = {1'b0, a_q[DIGIT-1:0]}
                 - {1'b0, b_q[DIGIT-1:0]}
                 - {{DIGIT{1'b0}}, brw_q};
        dig_w = '0;
        dig_w[DIGIT-1:0] = dig_diff[DIGIT-1:0];
        r_nxt = (r_q >> DIGIT) | (dig_w << (WIDTH - DIGIT));
        last  = (cnt_q == CW'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    brw_d   = Bin;
                    sa_d    = A[WIDTH-1];
                    sb_d    = B[WIDTH-1];
                    r_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                r_d   = r_nxt;
                brw_d = dig_diff[DIGIT];
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    d_d     = r_nxt;
                    bout_d  = dig_diff[DIGIT];
                    ovf_d   = (sa_q != sb_q) & (r_nxt[WIDTH-1] != sa_q);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = d_q;
    assign Bout = bout_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed checks of serial_sub at (8,1) plus a small
// parameter sweep at (8,4), (16,4) and (16,16).
module tb_serial_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       st0 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0;
    logic       bi0 = 1'b0;
    logic       busy0, done0, bo0, ov0;
    logic [7:0] d0;

    logic        ss = 1'b0;
    logic [15:0] sa = '0, sb = '0;
    logic        sbi = 1'b0;

    logic        busy1, done1, bo1, ov1;
    logic [7:0]  d1;
    logic        busy2, done2, bo2, ov2;
    logic [15:0] d2;
    logic        busy3, done3, bo3, ov3;
    logic [15:0] d3;

    int n_cmp = 0;
    int n_err = 0;

    serial_sub #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(st0), .A(a0), .B(b0), .Bin(bi0),
        .busy(busy0), .done(done0), .D(d0), .Bout(bo0), .OVF(ov0)
    );
    serial_sub #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst), .start(ss), .A(sa[7:0]), .B(sb[7:0]), .Bin(sbi),
        .busy(busy1), .done(done1), .D(d1), .Bout(bo1), .OVF(ov1)
    );
    serial_sub #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
        .clk(clk), .rst(rst), .start(ss), .A(sa), .B(sb), .Bin(sbi),
        .busy(busy2), .done(done2), .D(d2), .Bout(bo2), .OVF(ov2)
    );
    serial_sub #(.WIDTH(16), .DIGIT(16)) u_w16d16 (
        .clk(clk), .rst(rst), .start(ss), .A(sa), .B(sb), .Bin(sbi),
        .busy(busy3), .done(done3), .D(d3), .Bout(bo3), .OVF(ov3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic go8(input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input bit spam,
                       output int lat, output int bc);
        @(negedge clk);
        a0 = a; b0 = b; bi0 = bin; st0 = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        bc  = busy0 ? 1 : 0;
        st0 = spam;
        if (spam) begin
            a0 = 8'h5A; b0 = 8'hC3; bi0 = 1'b1;
        end
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done0) lat = k;
            else if (busy0) bc++;
            if (spam) a0 = a0 + 8'h11;
        end
        @(posedge clk); #1;
        st0 = 1'b0;
        check("done_one_cycle", {31'b0, done0}, 32'd0);
    endtask

    task automatic chk8(input string tag, input logic [7:0] ed,
                        input logic eb, input logic eo);
        check({tag, "_D"}, {24'b0, d0}, {24'b0, ed});
        check({tag, "_Bout"}, {31'b0, bo0}, {31'b0, eb});
        check({tag, "_OVF"}, {31'b0, ov0}, {31'b0, eo});
    endtask

    task automatic sweep(input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input string tag,
                         input logic [7:0] e1, input logic eb1, input logic eo1,
                         input logic [15:0] e2, input logic eb2, input logic eo2);
        int l1, l2, l3, c1, c2, c3;
        @(negedge clk);
        sa = a; sb = b; sbi = bin; ss = 1'b1;
        @(posedge clk); #1;
        ss = 1'b0;
        l1 = 0; l2 = 0; l3 = 0;
        c1 = busy1 ? 1 : 0;
        c2 = busy2 ? 1 : 0;
        c3 = busy3 ? 1 : 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done1 && l1 == 0) l1 = k;
            if (done2 && l2 == 0) l2 = k;
            if (done3 && l3 == 0) l3 = k;
            if (busy1) c1++;
            if (busy2) c2++;
            if (busy3) c3++;
        end
        check({tag, "_w8d4_lat"}, l1, 32'd2);
        check({tag, "_w16d4_lat"}, l2, 32'd4);
        check({tag, "_w16d16_lat"}, l3, 32'd1);
        check({tag, "_w16d4_busy"}, c2, 32'd4);
        check({tag, "_w8d4_D"}, {24'b0, d1}, {24'b0, e1});
        check({tag, "_w8d4_B"}, {31'b0, bo1}, {31'b0, eb1});
        check({tag, "_w8d4_V"}, {31'b0, ov1}, {31'b0, eo1});
        check({tag, "_w16d4_D"}, {16'b0, d2}, {16'b0, e2});
        check({tag, "_w16d4_B"}, {31'b0, bo2}, {31'b0, eb2});
        check({tag, "_w16d4_V"}, {31'b0, ov2}, {31'b0, eo2});
        check({tag, "_w16d16_D"}, {16'b0, d3}, {16'b0, e2});
        check({tag, "_w16d16_B"}, {31'b0, bo3}, {31'b0, eb2});
        check({tag, "_w16d16_V"}, {31'b0, ov3}, {31'b0, eo2});
    endtask

    initial begin
        int lat, bc, nd;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy0}, 32'd0);
        check("rst_done", {31'b0, done0}, 32'd0);
        check("rst_D", {24'b0, d0}, 32'd0);
        check("rst_flags", {30'b0, bo0, ov0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        go8(8'h35, 8'h12, 1'b0, 1'b0, lat, bc);
        check("basic_lat", lat, 32'd8);
        check("basic_busy", bc, 32'd8);
        chk8("basic", 8'h23, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_D", {24'b0, d0}, 32'h23);

        go8(8'h00, 8'h01, 1'b0, 1'b0, lat, bc);
        chk8("wrap", 8'hFF, 1'b1, 1'b0);
        go8(8'h10, 8'h10, 1'b1, 1'b0, lat, bc);
        chk8("bin", 8'hFF, 1'b1, 1'b0);
        go8(8'h80, 8'h01, 1'b0, 1'b0, lat, bc);
        chk8("ovf_neg", 8'h7F, 1'b0, 1'b1);

        go8(8'h7F, 8'hFF, 1'b0, 1'b1, lat, bc);
        check("spam_lat", lat, 32'd8);
        chk8("spam", 8'h80, 1'b1, 1'b1);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done0) nd++;
        end
        check("spam_no_extra_done", nd, 32'd0);
        chk8("spam_hold", 8'h80, 1'b1, 1'b1);

        @(negedge clk);
        a0 = 8'h35; b0 = 8'h12; bi0 = 1'b0; st0 = 1'b1;
        @(posedge clk); #1;
        st0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy0}, 32'd0);
        check("abort_done", {31'b0, done0}, 32'd0);
        chk8("abort", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done0 || busy0) nd++;
        end
        check("abort_no_done", nd, 32'd0);
        go8(8'hC8, 8'h37, 1'b1, 1'b0, lat, bc);
        check("after_abort_lat", lat, 32'd8);
        chk8("after_abort", 8'h90, 1'b0, 1'b0);

        sweep(16'h1234, 16'h5678, 1'b1, "sw1",
              8'hBB, 1'b1, 1'b0, 16'hBBBB, 1'b1, 1'b0);
        sweep(16'h8000, 16'h0001, 1'b0, "sw2",
              8'hFF, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        sweep(16'h7FF0, 16'h80F0, 1'b0, "sw3",
              8'h00, 1'b0, 1'b0, 16'hFF00, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
